bios_loader: RTL
================

BIOS_LOADER -- requirements
Module: bios_loader

Interface
REQ-001 SHALL have parameter BIOS_DEPTH, default 64, number of BIOS words scanned.
REQ-002 SHALL have parameter IMEM_BASE, default 0, first instruction-memory write address.
REQ-003 SHALL have port clk_auto, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, one-cycle request to begin a copy, sampled only in IDLE.
REQ-006 SHALL have port bios_addr, output, 32, word address driven to the BIOS ROM.
REQ-007 SHALL have port bios_data, input, 32, ROM word, valid exactly one clk_auto after bios_addr is presented.
REQ-008 SHALL have port imem_we, output, 1, instruction-memory write request.
REQ-009 SHALL have port imem_addr, output, 32, instruction-memory write address.
REQ-010 SHALL have port imem_data, output, 32, instruction-memory write data.
REQ-011 SHALL have port imem_ready, input, 1, memory accepts the write in any cycle where imem_we and imem_ready are both 1.
REQ-012 SHALL have port busy, output, 1, high from start acceptance until DONE is entered.
REQ-013 SHALL have port done, output, 1, sticky high in DONE.
REQ-014 SHALL have port no_hlt, output, 1, DONE was reached without finding hlt.
REQ-015 SHALL have port word_count, output, 7, number of words written in the current or last run.

Function
REQ-016 SHALL implement the states IDLE, ISSUE, WAIT, WRITE and DONE.
REQ-017 IDLE: with start=1, SHALL clear index, word_count and no_hlt, assert busy, and go to ISSUE.
REQ-018 ISSUE: SHALL drive bios_addr=index, then go to WAIT.
REQ-019 WAIT: SHALL capture bios_data into a data register, then go to WRITE, giving a fixed 2-cycle read latency.
REQ-020 WRITE: SHALL hold imem_we=1, imem_addr=IMEM_BASE+index and imem_data=captured word, all stable, until imem_ready=1.
REQ-021 On an accepted write SHALL increment word_count; opcode bits[31:26]=6'b011101 (hlt) SHALL then go to DONE.
REQ-022 On an accepted non-hlt write at index=BIOS_DEPTH-1 SHALL set no_hlt=1 and go to DONE.
REQ-023 On any other accepted write SHALL increment index and go to ISSUE.
REQ-024 DONE: busy=0, done=1, imem_we=0; start=1 SHALL restart as from IDLE, clearing done; start outside IDLE/DONE SHALL be ignored.
REQ-025 imem_we SHALL be 0 in every state except WRITE; a never-asserted imem_ready SHALL stall in WRITE indefinitely with outputs held.
REQ-026 index SHALL be 6 bits and word_count 7 bits, so a full 64-word copy reports 64 without wrap.

Reset
REQ-027 rst_n=0 SHALL force IDLE immediately, including mid-copy, with bios_addr=0, imem_we=0, imem_addr=0, imem_data=0, busy=0, done=0, no_hlt=0 and word_count=0.
REQ-028 After rst_n deasserts, the block SHALL act only on a new start.

Configuration
REQ-029 With BIOS_LOADER_CHECKSUM_EN defined, SHALL add a 32-bit output checksum: XOR of all accepted imem_data, cleared on reset and on start, updated on each accepted write.
REQ-030 Without BIOS_LOADER_CHECKSUM_EN, the checksum port and its logic SHALL be absent.

Structure
REQ-031 SHALL take the opcode constant OP_HLT, the state enum and the opcode field position [31:26] from the shared package mir_pkg.
REQ-032 SHALL be one flat module with no sub-module.

Verification
REQ-033 ROM word 0 = jump, words 1..45 arbitrary non-hlt, word 46 = hlt, imem_ready tied 1 -> 47 writes to addresses 0..46, done=1, word_count=47, no_hlt=0.
REQ-034 Same ROM, imem_ready low for 3 cycles on the write of index 5 -> imem_we, imem_addr=5 and imem_data held stable for 4 cycles; final results identical to REQ-033.
REQ-035 ROM with no hlt in 64 words -> 64 writes, word_count=64, no_hlt=1, done=1.
REQ-036 rst_n pulsed low during the write of index 10 -> IDLE, all outputs at reset values immediately; a new start copies again from index 0.
REQ-037 start held high in WAIT and WRITE -> no restart, index unchanged; start in DONE with IMEM_BASE=16 -> new copy writing to address 16 onward.
REQ-038 With BIOS_LOADER_CHECKSUM_EN, words 0x1,0x2, then hlt 0x74000000 -> checksum=0x74000003.

Source files
------------

// File: rtl/mir_pkg.sv
// mir_pkg: definitions shared across the mir boot path.
//   OP_HLT          opcode of the hlt instruction
//   OPC_HI/OPC_LO   position of the opcode field within an instruction word
//   loader_state_e  bios_loader FSM states
//   is_hlt()        true when an instruction word carries the hlt opcode
`timescale 1ns/1ps
package mir_pkg;

   localparam int         OPC_HI = 31;
   localparam int         OPC_LO = 26;
   localparam logic [5:0] OP_HLT = 6'b011101;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_WRITE,
      ST_DONE
   } loader_state_e;

   function automatic logic is_hlt(input logic [31:0] word);
      return word[OPC_HI:OPC_LO] == OP_HLT;
   endfunction

endpackage

// File: rtl/bios_loader.sv
// bios_loader: copies a boot image word by word from the BIOS ROM into
// instruction memory, stopping after a hlt word or after BIOS_DEPTH words.
//
// Parameters
//   BIOS_DEPTH   number of ROM words scanned (at most 64)
//   IMEM_BASE    instruction-memory address of the first copied word
// Ports
//   clk_auto     clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        one-cycle copy request, honoured in IDLE and DONE only
//   bios_addr    ROM word address
//   bios_data    ROM word, valid one cycle after bios_addr
//   imem_we      instruction-memory write request
//   imem_addr    instruction-memory write address
//   imem_data    instruction-memory write data
//   imem_ready   write accepted when imem_we and imem_ready are both high
//   busy         copy in progress
//   done         sticky completion flag
//   no_hlt       copy finished without meeting a hlt word
//   word_count   words written in the current or last copy
//   checksum     XOR of all accepted write data (BIOS_LOADER_CHECKSUM_EN only)
//
// Build option: define BIOS_LOADER_CHECKSUM_EN to add the checksum output.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start after reset
// ST_ISSUE  | bios_addr presents the current index to the ROM
// ST_WAIT   | ROM word arrives and is captured into the write data
// ST_WRITE  | write held on imem until imem_ready
// ST_DONE   | copy finished, done sticky, start begins a new copy
`timescale 1ns/1ps
module bios_loader
   import mir_pkg::*;
#(
   parameter int          BIOS_DEPTH = 64,
   parameter logic [31:0] IMEM_BASE  = 32'd0
) (
   input  logic        clk_auto,
   input  logic        rst_n,
   input  logic        start,
   output logic [31:0] bios_addr,
   input  logic [31:0] bios_data,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_data,
   input  logic        imem_ready,
   output logic        busy,
   output logic        done,
   output logic        no_hlt,
   output logic [6:0]  word_count
`ifdef BIOS_LOADER_CHECKSUM_EN
   ,
   output logic [31:0] checksum
`endif
);

   localparam logic [5:0] LAST_IDX = 6'(BIOS_DEPTH - 1);

   loader_state_e state;
   logic [5:0]    index;
   logic          start_ok;

   assign start_ok = start && (state == ST_IDLE || state == ST_DONE);

   always_ff @(posedge clk_auto or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         index      <= '0;
         bios_addr  <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_data  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         no_hlt     <= 1'b0;
         word_count <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  index      <= '0;
                  bios_addr  <= '0;
                  word_count <= '0;
                  no_hlt     <= 1'b0;
                  done       <= 1'b0;
                  busy       <= 1'b1;
                  state      <= ST_ISSUE;
               end
            end
            ST_ISSUE: state <= ST_WAIT;
            ST_WAIT: begin
               // imem_data doubles as the captured-word register
               imem_data <= bios_data;
               imem_addr <= IMEM_BASE + {26'd0, index};
               imem_we   <= 1'b1;
               state     <= ST_WRITE;
            end
            ST_WRITE: begin
               if (imem_ready) begin
                  imem_we    <= 1'b0;
                  word_count <= word_count + 7'd1;
                  if (is_hlt(imem_data)) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= ST_DONE;
                  end else if (index == LAST_IDX) begin
                     no_hlt <= 1'b1;
                     busy   <= 1'b0;
                     done   <= 1'b1;
                     state  <= ST_DONE;
                  end else begin
                     index     <= index + 6'd1;
                     bios_addr <= {26'd0, index + 6'd1};
                     state     <= ST_ISSUE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef BIOS_LOADER_CHECKSUM_EN
   always_ff @(posedge clk_auto or negedge rst_n) begin
      if (!rst_n)
         checksum <= '0;
      else if (start_ok)
         checksum <= '0;
      else if (state == ST_WRITE && imem_ready)
         checksum <= checksum ^ imem_data;
   end
`endif

endmodule
